rope_ctrl: RTL

Downstream consumer of the two per-player push-pulse stages in the tug-of-war game. It takes each player's one-cycle `winrnd` pulse and moves the rope marker one LED toward that player. It drives the one-hot LED bar, detects when a player has pulled the marker onto their end LED, latches the winner and blinks the winning end LED until cleared.

---
 rtl/rope_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/rope_ctrl.sv
// Tug-of-war rope marker: moves a one-hot LED toward the pulling player,
// latches the winner on reaching an end LED and blinks that end until cleared.
module rope_ctrl #(
  parameter int NLED      = 9,
  parameter int BLINK_DIV = 250
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            winrnd_l,
  input  logic            winrnd_r,
  input  logic            clr,
  output logic [NLED-1:0] leds,
  output logic            winner_l,
  output logic            winner_r
);

  localparam int PW = $clog2(NLED);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] CTR  = PW'((NLED - 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(NLED - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    WIN_L = 2'd1,
    WIN_R = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [PW-1:0]   pos, pos_n;
  logic [BW-1:0]   bcnt, bcnt_n;
  logic            bon, bon_n;
  logic [NLED-1:0] leds_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= PLAY;
      pos      <= CTR;
      bcnt     <= '0;
      bon      <= 1'b1;
      leds     <= NLED'(1) << CTR;
      winner_l <= 1'b0;
      winner_r <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      bcnt     <= bcnt_n;
      bon      <= bon_n;
      leds     <= leds_n;
      winner_l <= (state_n == WIN_L);
      winner_r <= (state_n == WIN_R);
    end
  end

  always_comb begin
    state_n = state;
    pos_n   = pos;
    bcnt_n  = bcnt;
    bon_n   = bon;
    case (state)
      PLAY: begin
        // Blink phase is held at its restart value so every win entry starts lit.
        bcnt_n = '0;
        bon_n  = 1'b1;
        if (clr) begin
          pos_n = CTR;
        end else if (winrnd_l && !winrnd_r) begin
          pos_n = pos + PW'(1);
          if (pos_n == LAST) state_n = WIN_L;
        end else if (winrnd_r && !winrnd_l) begin
          pos_n = pos - PW'(1);
          if (pos_n == '0) state_n = WIN_R;
        end
      end
      WIN_L, WIN_R: begin
        if (clr) begin
          state_n = PLAY;
          pos_n   = CTR;
          bcnt_n  = '0;
          bon_n   = 1'b1;
        end else if (bcnt == BMAX) begin
          bcnt_n = '0;
          bon_n  = ~bon;
        end else begin
          bcnt_n = bcnt + BW'(1);
        end
      end
      default: begin
        state_n = PLAY;
        pos_n   = CTR;
        bcnt_n  = '0;
        bon_n   = 1'b1;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they register on the same edge.
  always_comb begin
    leds_n = '0;
    case (state_n)
      PLAY:    leds_n = NLED'(1) << pos_n;
      WIN_L:   leds_n[NLED-1] = bon_n;
      WIN_R:   leds_n[0] = bon_n;
      default: leds_n = '0;
    endcase
  end

endmodule
